// File: rtl/trail_painter.sv
// trail_painter: two-phase square-trail animation rendered as a registered RGB565 pixel stream
module trail_painter #(
    parameter int          SQ        = 15,
    parameter int          MIN_X     = 6,
    parameter int          MAX_X     = 90,
    parameter int          MIN_Y     = 4,
    parameter int          MAX_Y     = 60,
    parameter int          STEP_A    = 1,
    parameter int          STEP_B    = 2,
    parameter int          DWELL     = 45,
    parameter int          TICK_DIV  = 1666667,
    parameter logic [15:0] COL_A     = 16'h07E0,
    parameter logic [15:0] COL_B     = 16'hF800,
    parameter logic [15:0] COL_BG    = 16'h0000,
    parameter bit          AUTO_LOOP = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_a,
    input  logic        start_b,
    input  logic [12:0] pixel_index,
    output logic [15:0] colour,
    output logic        busy,
    output logic [3:0]  state
);
    localparam int XR = MAX_X - SQ;
    localparam int YB = MAX_Y - SQ;
    localparam int CW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DWELL + 1);

    typedef enum logic [3:0] {
        IDLE, A_RIGHT, A_DW1, A_DOWN, A_DW2, A_LEFT, A_DW3, ARMED, B_RIGHT, B_UP, B_LEFT, DONE
    } state_t;

    state_t        st;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dw;
    logic [7:0]    hx, hy;
    logic          prev_a, prev_b, pend_a, pend_b;
    logic          tick, rise_a, rise_b, dw_end;
    logic [7:0]    step, inc_x, dec_x, inc_y, dec_y;

    assign tick   = cnt == CW'(TICK_DIV - 1);
    assign rise_a = start_a & ~prev_a;
    assign rise_b = start_b & ~prev_b;
    assign dw_end = dw == DW'(DWELL - 1);
    assign step   = (st inside {B_RIGHT, B_UP, B_LEFT}) ? 8'(STEP_B) : 8'(STEP_A);
    // Saturate in 9 bits so the clamp is applied before the head register ever sees the value
    assign inc_x  = ({1'b0, hx} + {1'b0, step} >= 9'(XR)) ? 8'(XR) : hx + step;
    assign dec_x  = ({1'b0, hx} <= 9'(MIN_X) + {1'b0, step}) ? 8'(MIN_X) : hx - step;
    assign inc_y  = ({1'b0, hy} + {1'b0, step} >= 9'(YB)) ? 8'(YB) : hy + step;
    assign dec_y  = ({1'b0, hy} <= 9'(MIN_Y) + {1'b0, step}) ? 8'(MIN_Y) : hy - step;
    assign busy   = !(st inside {IDLE, ARMED});
    assign state  = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= IDLE;
            hx     <= 8'(MIN_X);
            hy     <= 8'(MIN_Y);
            cnt    <= '0;
            dw     <= '0;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
        end else begin
            cnt    <= tick ? '0 : cnt + 1'b1;
            prev_a <= start_a;
            prev_b <= start_b;
            // A request only survives while the state that can consume it is current
            pend_a <= (st == IDLE && !(tick && pend_a)) ? (pend_a | rise_a) : 1'b0;
            pend_b <= (st == ARMED && !(tick && pend_b)) ? (pend_b | rise_b) : 1'b0;
            if (tick) begin
                case (st)
                    IDLE: if (pend_a) begin
                        st <= A_RIGHT;
                        hx <= 8'(MIN_X);
                        hy <= 8'(MIN_Y);
                    end
                    A_RIGHT, B_RIGHT: if (hx < 8'(XR)) hx <= inc_x;
                        else st <= (st == A_RIGHT) ? A_DW1 : B_UP;
                    A_DOWN: if (hy < 8'(YB)) hy <= inc_y;
                        else st <= A_DW2;
                    B_UP: if (hy > 8'(MIN_Y)) hy <= dec_y;
                        else st <= B_LEFT;
                    A_LEFT, B_LEFT: if (hx > 8'(MIN_X)) hx <= dec_x;
                        else st <= (st == A_LEFT) ? A_DW3 : DONE;
                    A_DW1, A_DW2, A_DW3, DONE: begin
                        dw <= dw_end ? '0 : dw + 1'b1;
                        if (dw_end) begin
                            case (st)
                                A_DW1: st <= A_DOWN;
                                A_DW2: st <= A_LEFT;
                                A_DW3: begin
                                    st <= ARMED;
                                    hx <= 8'(MIN_X);
                                    hy <= 8'(YB);
                                end
                                default: begin
                                    st <= AUTO_LOOP ? A_RIGHT : IDLE;
                                    hx <= 8'(MIN_X);
                                    hy <= 8'(MIN_Y);
                                end
                            endcase
                        end
                    end
                    ARMED: if (pend_b) st <= B_RIGHT;
                    default: st <= IDLE;
                endcase
            end
        end
    end

    int          r, c, x, y;
    logic        in_t, in_r, in_b, in_p, sq_s, sq_e, pa, pb;
    logic [15:0] nxt;

    always_comb begin
        r    = int'(pixel_index) / 96;
        c    = int'(pixel_index) % 96;
        x    = int'(hx);
        y    = int'(hy);
        in_t = r >= MIN_Y && r < MIN_Y + SQ && c >= MIN_X && c < MAX_X;
        in_r = c >= XR && c < MAX_X && r >= MIN_Y && r < MAX_Y;
        in_b = r >= YB && r < MAX_Y && c >= MIN_X && c < MAX_X;
        in_p = in_t || in_r || in_b;
        sq_s = r >= MIN_Y && r < MIN_Y + SQ && c >= MIN_X && c < MIN_X + SQ;
        sq_e = r >= YB && r < YB + SQ && c >= MIN_X && c < MIN_X + SQ;
        pa   = (st inside {ARMED, B_RIGHT, B_UP, B_LEFT}) ? in_p : 1'b0;
        pb   = 1'b0;
        case (st)
            IDLE:           pa = sq_s;
            A_RIGHT, A_DW1: pa = in_t && c < x + SQ;
            A_DOWN, A_DW2:  pa = in_t || (in_r && r < y + SQ);
            A_LEFT, A_DW3:  pa = in_t || in_r || (in_b && c >= x);
            ARMED:          pb = sq_e;
            B_RIGHT:        pb = in_b && c < x + SQ;
            B_UP:           pb = in_b || (in_r && r >= y);
            B_LEFT:         pb = in_b || in_r || (in_t && c >= x);
            DONE:           pb = in_p;
            default:        pb = 1'b0;
        endcase
        nxt = (pixel_index >= 13'd6144) ? COL_BG : pb ? COL_B : pa ? COL_A : COL_BG;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) colour <= COL_BG;
        else colour <= nxt;
    end
endmodule

// File: doc/trail_painter.md
TRAIL_PAINTER -- requirements
Module: trail_painter

Interface
REQ-001 The module SHALL have the following parameters:
- SQ, default 15, square edge in pixels.
- MIN_X/MAX_X, defaults 6/90, horizontal path bounds; MAX_X is exclusive.
- MIN_Y/MAX_Y, defaults 4/60, vertical path bounds; MAX_Y is exclusive.
- STEP_A, default 1, pixels per tick for phase A.
- STEP_B, default 2, pixels per tick for phase B.
- DWELL, default 45, ticks held at each phase-A corner and in DONE.
- TICK_DIV, default 1666667, clk cycles per movement tick.
- COL_A / COL_B / COL_BG, defaults 16'h07E0 / 16'hF800 / 16'h0000, RGB565 colours.
- AUTO_LOOP, default 0; when 1, DONE re-enters A_RIGHT instead of IDLE.

REQ-002 The module SHALL have the following ports:
- clk, in, 1, system clock; this block uses one clock.
- reset, in, 1, asynchronous, active-high.
- start_a, in, 1, request phase A.
- start_b, in, 1, request phase B.
- pixel_index, in, 13, OLED pixel address, row-major, 96 wide.
- colour, out, 16, registered RGB565 pixel.
- busy, out, 1, animation in motion.
- state, out, 4, current FSM state.

Function
REQ-003 Tick: a counter SHALL count 0..TICK_DIV-1 and assert a one-cycle tick at TICK_DIV-1. All FSM, head and dwell updates SHALL occur only on tick.
REQ-004 A rising edge of start_a or start_b (previous-cycle sample 0, current 1) SHALL set a pending flag. The flag SHALL clear when consumed, or when its FSM state is left without consuming it.
REQ-005 States: IDLE, A_RIGHT, A_DW1, A_DOWN, A_DW2, A_LEFT, A_DW3, ARMED, B_RIGHT, B_UP, B_LEFT, DONE.
REQ-006 Transitions:
- IDLE with pending_a -> A_RIGHT; head set to (MIN_X, MIN_Y).
- A_RIGHT: while hx < MAX_X-SQ, hx <= min(hx+STEP_A, MAX_X-SQ); otherwise -> A_DW1.
- A_DOWN: while hy < MAX_Y-SQ, hy <= min(hy+STEP_A, MAX_Y-SQ); otherwise -> A_DW2.
- A_LEFT: while hx > MIN_X, hx <= max(hx-STEP_A, MIN_X); otherwise -> A_DW3.
- Each A_DWn, and DONE, SHALL remain for exactly DWELL ticks, then advance: A_DW1->A_DOWN, A_DW2->A_LEFT, A_DW3->ARMED (head <= (MIN_X, MAX_Y-SQ)).
- ARMED with pending_b -> B_RIGHT.
- B_RIGHT, B_UP, B_LEFT: same saturating rule as the A moves using STEP_B; B_UP decrements hy toward MIN_Y. Order is B_RIGHT -> B_UP -> B_LEFT -> DONE.
- DONE -> IDLE, or -> A_RIGHT with head reset when AUTO_LOOP=1.
REQ-007 Head arithmetic SHALL be 8-bit with the clamp applied before the register write. The head SHALL never leave [MIN_X, MAX_X-SQ] x [MIN_Y, MAX_Y-SQ].
REQ-008 Regions:
- T = rows [MIN_Y, MIN_Y+SQ), cols [MIN_X, MAX_X).
- R = cols [MAX_X-SQ, MAX_X), rows [MIN_Y, MAX_Y).
- Bt = rows [MAX_Y-SQ, MAX_Y), cols [MIN_X, MAX_X).
- P = T ∪ R ∪ Bt.
REQ-009 Colour per state; first matching rule wins, else COL_BG:
- IDLE: SQ square at (MIN_X, MIN_Y) is A.
- A_RIGHT/A_DW1: T restricted to cols < hx+SQ is A.
- A_DOWN/A_DW2: T is A; R restricted to rows < hy+SQ is A.
- A_LEFT/A_DW3: T and R are A; Bt restricted to cols >= hx is A.
- ARMED: SQ square at (MIN_X, MAX_Y-SQ) is B; P is A.
- B_RIGHT: Bt restricted to cols < hx+SQ is B; P is A.
- B_UP: Bt, plus R restricted to rows >= hy, is B; P is A.
- B_LEFT: Bt, R, plus T restricted to cols >= hx, is B; P is A.
- DONE: P is B.
REQ-010 colour SHALL be registered with 1-cycle latency from pixel_index. pixel_index >= 6144 SHALL yield COL_BG.
REQ-011 busy SHALL be 1 in every state except IDLE and ARMED.

Reset
REQ-012 When reset is asserted, the block SHALL immediately set:
- state = IDLE
- head = (MIN_X, MIN_Y)
- colour = COL_BG
- tick counter, dwell counter, pending flags, edge registers = 0
REQ-013 Reset mid-animation SHALL abandon the animation. No movement SHALL occur until a new start_a edge arrives after release.

Verification (TICK_DIV=4, DWELL=3, other parameters default)
REQ-014 Reset, then idle. Expected: pixel_index 390 (row 4, col 6) -> COL_A; 389 -> COL_BG; busy=0.
REQ-015 start_a pulsed for 1 cycle. Expected: A_RIGHT takes 69 moving ticks to reach hx=75, plus 1 tick -> A_DW1; after 3 ticks -> A_DOWN.
REQ-016 start_a held high continuously. Expected: exactly one run is started; once the run returns to IDLE, no second start occurs until start_a is deasserted and reasserted.
REQ-017 In ARMED, pulse start_b. Expected: head sequence 6, 8, ..., 74, 75 (clamp); then B_UP runs from hy=45 to 4; then B_LEFT; then DONE. In DONE, pixel (row 50, col 80) -> COL_B.
REQ-018 Assert reset during B_UP. Expected: next cycle state=IDLE and colour=0 (COL_BG); start_b pulses are then ignored.
REQ-019 AUTO_LOOP=1. Expected: DONE -> A_RIGHT after 3 ticks, with no start_a.
